// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over one
// word-addressed memory port with a ready handshake.
module mips_multicycle_core #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   mdr_q, mdr_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic              halted_q, halted_d;
  logic              illegal_q, illegal_d;
  logic [XLEN-1:0]   rf_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic [31:0]       fetch_word;

  if (XLEN >= 32) begin : g_wide
    assign fetch_word = mem_rdata[31:0];
  end else begin : g_narrow
    assign fetch_word = {{(32-XLEN){1'b0}}, mem_rdata};
  end

  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] target;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign func   = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign target = ir_q[25:0];

  // Shamt and high target/data bits are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{ir_q, mem_rdata};

  logic [XLEN-1:0]   sext_imm, zext_imm;
  logic [ADDR_W-1:0] br_tgt;

  assign sext_imm = XLEN'($signed(imm));
  assign zext_imm = XLEN'(imm);
  assign br_tgt   = pc_q + ADDR_W'($signed(imm));

  logic d_add, d_sub, d_and, d_or, d_slt, d_jr;
  logic d_lw, d_sw, d_addi, d_xori, d_beq, d_bne;
  logic d_j, d_jal, d_halt, d_ill, d_alu_r;

  always_comb begin
    d_add  = 1'b0;
    d_sub  = 1'b0;
    d_and  = 1'b0;
    d_or   = 1'b0;
    d_slt  = 1'b0;
    d_jr   = 1'b0;
    d_lw   = 1'b0;
    d_sw   = 1'b0;
    d_addi = 1'b0;
    d_xori = 1'b0;
    d_beq  = 1'b0;
    d_bne  = 1'b0;
    d_j    = 1'b0;
    d_jal  = 1'b0;
    d_halt = 1'b0;
    d_ill  = 1'b0;
    case (op)
      6'b000000: begin
        case (func)
          6'b100000: d_add = 1'b1;
          6'b100010: d_sub = 1'b1;
          6'b100100: d_and = 1'b1;
          6'b100101: d_or  = 1'b1;
          6'b101010: d_slt = 1'b1;
          6'b001000: d_jr  = 1'b1;
          default:   d_ill = 1'b1;
        endcase
      end
      6'b100011: d_lw   = 1'b1;
      6'b101011: d_sw   = 1'b1;
      6'b001000: d_addi = 1'b1;
      6'b001110: d_xori = 1'b1;
      6'b000100: d_beq  = 1'b1;
      6'b000101: d_bne  = 1'b1;
      6'b000010: d_j    = 1'b1;
      6'b000011: d_jal  = 1'b1;
      6'b111111: d_halt = 1'b1;
      default:   d_ill  = 1'b1;
    endcase
  end

  assign d_alu_r = d_add | d_sub | d_and | d_or | d_slt;

  logic [XLEN-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    if (d_add)               alu_res = a_q + b_q;
    else if (d_sub)          alu_res = a_q - b_q;
    else if (d_and)          alu_res = a_q & b_q;
    else if (d_or)           alu_res = a_q | b_q;
    else if (d_slt)          alu_res = XLEN'($signed(a_q) < $signed(b_q));
    else if (d_xori)         alu_res = a_q ^ zext_imm;
    else if (d_addi | d_lw | d_sw) alu_res = a_q + sext_imm;
  end

  logic [XLEN-1:0] rs_val, rt_val;

  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    mdr_d     = mdr_q;
    alu_d     = alu_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = fetch_word;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = S_EXEC;
        if (d_ill) begin
          halted_d  = 1'b1;
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (d_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (d_j) begin
          pc_d    = ADDR_W'(target);
          state_d = S_FETCH;
        end else if (d_jal) begin
          // pc_q already holds the return address here
          rf_we    = 1'b1;
          rf_waddr = 5'd31;
          rf_wdata = XLEN'(pc_q);
          pc_d     = ADDR_W'(target);
          state_d  = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_d   = alu_res;
        state_d = S_FETCH;
        if ((d_beq && a_q == b_q) || (d_bne && a_q != b_q))
          pc_d = br_tgt;
        if (d_jr)
          pc_d = ADDR_W'(a_q);
        if (d_lw || d_sw)
          state_d = S_MEM;
        if (d_alu_r || d_addi || d_xori)
          state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          if (d_lw) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = d_alu_r ? rd : rt;
        rf_wdata = d_lw ? mdr_q : alu_q;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdr_q     <= '0;
      alu_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      mdr_q     <= mdr_d;
      alu_q     <= alu_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      if (rf_we && rf_waddr != 5'd0)
        rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Port outputs are forced quiet while reset is held.
  logic in_fetch, in_mem;

  assign in_fetch = !rst && (state_q == S_FETCH);
  assign in_mem   = !rst && (state_q == S_MEM);

  assign mem_req   = in_fetch || in_mem;
  assign mem_we    = in_mem && d_sw;
  assign mem_wdata = (in_mem && d_sw) ? b_q : '0;
  assign mem_addr  = in_fetch ? pc_q :
                     in_mem   ? ADDR_W'(alu_q) : '0;

  assign pc      = pc_q;
  assign state   = state_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small program plus
// wait-state memory model, halt/illegal and async-reset checks.
module tb_mips_multicycle_core;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [9:0]  pc;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;

  mips_multicycle_core #(
    .XLEN(32),
    .ADDR_W(10),
    .RESET_PC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc(pc),
    .state(state),
    .halted(halted),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int          wait_n = 0;
  int          wcnt = 0;
  int          st_cnt = 0;
  logic [9:0]  st_addr = '0;
  logic [31:0] st_data = '0;

  // Data accesses (state 3) get wait_n wait states; fetches none.
  assign mem_ready = (state != 3'd3) || (wcnt >= wait_n);
  assign mem_rdata = (st_cnt != 0 && mem_addr == st_addr) ?
                     st_data : mem[mem_addr];

  always @(posedge clk) begin
    if (!mem_req) begin
      wcnt <= 0;
    end else if (mem_ready) begin
      wcnt <= 0;
      if (mem_we) begin
        st_cnt  <= st_cnt + 1;
        st_addr <= mem_addr;
        st_data <= mem_wdata;
      end
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(state == 3'd0 || state == 3'd5) && n < 40);
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs,
    input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op,
    input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op,
    input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  int n;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4]  = i_ins(6'b001000, 5'd0, 5'd1, 16'hFFFD);
    mem[5]  = r_ins(5'd1, 5'd1, 5'd2, 6'b100000);
    mem[6]  = r_ins(5'd1, 5'd0, 5'd3, 6'b101010);
    mem[7]  = i_ins(6'b001000, 5'd0, 5'd0, 16'd7);
    mem[8]  = i_ins(6'b101011, 5'd0, 5'd2, 16'd5);
    mem[9]  = i_ins(6'b001000, 5'd1, 5'd1, 16'd1);
    mem[10] = i_ins(6'b000101, 5'd1, 5'd0, 16'hFFFE);
    mem[11] = i_ins(6'b000100, 5'd1, 5'd2, 16'd5);
    mem[12] = j_ins(6'b000011, 26'd20);
    mem[13] = j_ins(6'b111111, 26'd0);
    mem[20] = i_ins(6'b100011, 5'd0, 5'd4, 16'd5);
    mem[21] = r_ins(5'd31, 5'd0, 5'd0, 6'b001000);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 10'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_pc", pc, 10'd4);
    chk("rst_state", state, 3'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, 10'd4);
    tick();
    chk("fetch_pc", pc, 10'd5);
    chk("fetch_state", state, 3'd1);
    run_instr(n);
    chk("addi_rest_cycles", n, 3);
    chk("addi_r1", dut.rf_q[1], 32'hFFFF_FFFD);

    run_instr(n);
    chk("add_cycles", n, 4);
    chk("add_r2", dut.rf_q[2], 32'hFFFF_FFFA);
    run_instr(n);
    chk("slt_cycles", n, 4);
    chk("slt_r3", dut.rf_q[3], 32'd1);
    run_instr(n);
    chk("addi_r0_cycles", n, 4);
    chk("r0_zero", dut.rf_q[0], 32'd0);

    wait_n = 2;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("sw_state", state, 3'd3);
      chk("sw_we", mem_we, 1'b1);
      chk("sw_addr", mem_addr, 10'd5);
      chk("sw_wdata", mem_wdata, 32'hFFFF_FFFA);
      tick();
    end
    chk("sw_done_state", state, 3'd0);
    chk("sw_done_pc", pc, 10'd9);

    run_instr(n);
    chk("loop_addi_cycles", n, 4);
    run_instr(n);
    chk("bne_cycles", n, 3);
    chk("bne_taken_pc", pc, 10'd9);
    run_instr(n);
    run_instr(n);
    run_instr(n);
    chk("loop_r1", dut.rf_q[1], 32'd0);
    run_instr(n);
    chk("bne_not_taken_pc", pc, 10'd11);

    run_instr(n);
    chk("beq_cycles", n, 3);
    chk("beq_not_taken_pc", pc, 10'd12);
    run_instr(n);
    chk("jal_cycles", n, 2);
    chk("jal_pc", pc, 10'd20);
    chk("jal_r31", dut.rf_q[31], 32'd13);

    run_instr(n);
    chk("lw_wait_cycles", n, 7);
    chk("lw_r4", dut.rf_q[4], 32'hFFFF_FFFA);
    run_instr(n);
    chk("jr_cycles", n, 3);
    chk("jr_pc", pc, 10'd13);

    run_instr(n);
    chk("halt_cycles", n, 2);
    chk("halt_state", state, 3'd5);
    chk("halt_halted", halted, 1'b1);
    chk("halt_illegal", illegal, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_no_req", mem_req, 1'b0);
    end

    #2;
    rst = 1'b1;
    #1;
    chk("rst2_halted", halted, 1'b0);
    mem[4] = j_ins(6'b010000, 26'd0);
    wait_n = 0;
    @(negedge clk);
    rst = 1'b0;
    run_instr(n);
    chk("ill_cycles", n, 2);
    chk("ill_halted", halted, 1'b1);
    chk("ill_illegal", illegal, 1'b1);

    #2;
    rst = 1'b1;
    mem[4] = i_ins(6'b100011, 5'd0, 5'd5, 16'd7);
    mem[7] = 32'h1234_5678;
    wait_n = 20;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("mid_state", state, 3'd3);
    chk("mid_req", mem_req, 1'b1);
    chk("mid_addr", mem_addr, 10'd7);
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("abort_req", mem_req, 1'b0);
    chk("abort_addr", mem_addr, 10'd0);
    chk("abort_state", state, 3'd0);
    chk("abort_pc", pc, 10'd4);
    repeat (3) tick();
    chk("abort_r5", dut.rf_q[5], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    chk("after_abort_r5", dut.rf_q[5], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multicycle MIPS-subset processor core: successor of the fixed 32-bit, internal-memory multicycle CPU. Executes one instruction at a time through FETCH/DECODE/EXEC/MEM/WB. Adds an asynchronous reset, an external word-addressed memory port with ready handshake (wait states), PC-relative branches, more instructions, a hardwired-zero r0, and halt/illegal-instruction reporting. Sits between the testbench/memory model and the future pipelined core as the reference ISA model.

## Interface
- XLEN, 32: datapath and register width (>=16).
- ADDR_W, 10: word-address width of memory port and PC.
- RESET_PC, 0: PC value loaded on reset (ADDR_W bits).
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  XLEN  store data.
- mem_rdata  in  XLEN  load/fetch data, valid when mem_ready=1.
- mem_ready  in  1  access completes on the edge where mem_req&mem_ready.
- pc  out  ADDR_W  current PC (debug).
- state  out  3  FSM state encoding (debug).
- halted  out  1  core stopped.
- illegal  out  1  stop cause was an undefined opcode/func.

## Operation
- Instruction fields as MIPS: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], func[5:0], imm[15:0], target[25:0]. Instructions are 32 bits; when XLEN>32 the upper bits of the fetched word are ignored.
- Register file: 32 x XLEN. Reads of r0 return 0. Writes to r0 are discarded.
- Supported: R-type (op 000000) ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010 (signed), JR 001000; LW 100011, SW 101011, ADDI 001000 (sign-ext), XORI 001110 (zero-ext), BEQ 000100, BNE 000101, J 000010, JAL 000011, HALT 111111.
- Any other opcode or R-type func: go to HALT with illegal=1.
- Arithmetic is modulo 2^XLEN. There are no overflow traps. The LW/SW address is (rs + sext(imm)) truncated to ADDR_W.
- PC is a word address. FETCH completion sets PC <= PC+1, wrapping at 2^ADDR_W.
- Branch taken: PC <= PC+1+sext(imm), truncated to ADDR_W.
- J/JAL: PC <= target[ADDR_W-1:0]. JAL writes r31 <= the incremented PC, zero-extended.
- JR: PC <= rs[ADDR_W-1:0].
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Holds until mem_ready, then latches IR and goes to DECODE.
  - DECODE: latches A=rs and B=rt. J completes here (goes to FETCH). JAL completes here (writes r31, goes to FETCH). HALT and illegal instructions go to HALT. All others go to EXEC.
  - EXEC: branches and JR go to FETCH. ALU ops and ADDI/XORI go to WB. LW/SW go to MEM.
  - MEM: mem_req=1, with mem_we=1 and mem_wdata=B for SW. Holds until mem_ready. SW then goes to FETCH. LW latches MDR and goes to WB.
  - WB: writes rd (R-type) or rt (LW/ADDI/XORI), then goes to FETCH.
  - HALT: terminal until rst. mem_req=0.
- mem_req is deasserted in DECODE, EXEC, WB and HALT. mem_addr, mem_we and mem_wdata are held stable while mem_req=1 and mem_ready=0.

## Timing
- Reset (asynchronous assert, takes effect immediately): PC=RESET_PC, state=FETCH, all registers 0, IR/A/B/MDR/ALU result 0, halted=0, illegal=0.
  - Outputs during reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_req rises in the first cycle after rst deasserts.
- Reset mid-access abandons the transaction. A mem_ready arriving during reset is ignored.
- Cycle counts with zero wait states (each wait state adds 1 to FETCH or MEM):
  - J, JAL, HALT: 2 cycles.
  - BEQ, BNE, JR: 3 cycles.
  - SW, R-type ALU ops, ADDI, XORI: 4 cycles.
  - LW: 5 cycles.
- Memory handshake: the access completes on the edge where mem_req&mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready held high continuously means zero wait states.
- Register write in WB is visible to the next instruction's DECODE.
- halted and illegal are registered and assert on the edge entering HALT.

## Test plan
- Reset/fetch: set RESET_PC=4 and release rst with mem_ready=1. Expect mem_req=1 and mem_addr=4 on the first cycle, and pc=5 after the FETCH edge.
- ALU and r0: run ADDI r1,r0,-3 (r1 becomes XLEN'hFF..FD), then ADD r2,r1,r1 (r2 = -6), then SLT r3,r1,r0 (r3=1), then ADDI r0,r0,7. Afterwards r0 reads 0. Each instruction takes 4 cycles with zero wait.
- Load/store with 2 wait states: SW r2,5(r0) shows mem_we=1, mem_addr=5 and mem_wdata=-6, held for 3 cycles. A following LW r4,5(r0) returns -6 in r4, and the LW takes 7 cycles.
- Control flow:
  - BNE r1,r0,-2 at PC=10 is taken to PC 9.
  - BEQ with unequal operands is not taken (PC=PC+1).
  - JAL 20 at PC=12 gives r31=13 and PC=20. A later JR r31 returns to PC 13.
- Halt/illegal: opcode 111111 gives halted=1, illegal=0, and mem_req stays 0 for 10 cycles. Opcode 010000 gives halted=1, illegal=1.
- Async reset mid-MEM: assert rst between clock edges during an LW wait state. Outputs clear immediately, and the write to rt never occurs.
